tick_phase_sequencer: RTL and testbench

//  Programmable timing sequencer built around a modulo tick divider. Holds a table of NPHASE

---
 rtl/tick_phase_sequencer_pkg.sv | 17 +
 rtl/tick_phase_sequencer_if.sv | 30 +++
 rtl/tick_phase_sequencer_divider.sv | 36 +++
 rtl/tick_phase_sequencer.sv | 121 ++++++++++++
 tb/tb_tick_phase_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_phase_sequencer_pkg.sv
// Shared state encodings and default widths for the tick phase sequencer and its bench.
package tick_phase_sequencer_pkg;

  localparam int BIT_SZ_DEF = 16;
  localparam int NPHASE_DEF = 4;
  localparam int REP_SZ_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == S_LOAD) || (st == S_RUN);
  endfunction

endpackage

// File: rtl/tick_phase_sequencer_if.sv
// Control, table-write and status bundle of the tick phase sequencer.
interface tick_phase_sequencer_if #(
  parameter int BIT_SZ = 16,
  parameter int NPHASE = 4,
  parameter int REP_SZ = 8
);
  localparam int PH_SZ = $clog2(NPHASE);

  logic              enable;
  logic              start;
  logic              abort;
  logic              cfg_we;
  logic [PH_SZ-1:0]  cfg_addr;
  logic [BIT_SZ-1:0] cfg_modulo;
  logic [REP_SZ-1:0] cfg_reps;
  logic              tick;
  logic [PH_SZ-1:0]  phase;
  logic              busy;
  logic              done;

  modport master (
    output enable, start, abort, cfg_we, cfg_addr, cfg_modulo, cfg_reps,
    input  tick, phase, busy, done
  );

  modport slave (
    input  enable, start, abort, cfg_we, cfg_addr, cfg_modulo, cfg_reps,
    output tick, phase, busy, done
  );
endinterface

// File: rtl/tick_phase_sequencer_divider.sv
// Modulo tick divider: counts enabled clocks while running, pulses tick on each wrap.
module tick_phase_sequencer_divider #(
  parameter int BIT_SZ = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              enable,
  input  logic              clear,
  input  logic [BIT_SZ-1:0] modulo,
  output logic              tick,
  output logic              wrap
);
  localparam logic [BIT_SZ-1:0] ONE = BIT_SZ'(1);

  logic [BIT_SZ-1:0] count;

  // modulo-1 is only meaningful once a zero modulo has been ruled out
  assign wrap = run && enable && (modulo != '0) && (count == modulo - ONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap)
        count <= '0;
      else if (run && enable)
        count <= count + ONE;
    end
  end
endmodule

// File: rtl/tick_phase_sequencer.sv
// Table-driven tick sequencer: plays NPHASE {modulo, reps} entries as tick bursts.
// Define TICK_SEQ_LOOP_EN to replay the table continuously instead of one-shot.
module tick_phase_sequencer
  import tick_phase_sequencer_pkg::*;
#(
  parameter int BIT_SZ = 16,
  parameter int NPHASE = 4,
  parameter int REP_SZ = 8
) (
  input logic                  clock,
  input logic                  reset,
  tick_phase_sequencer_if.slave bus
);
  localparam int               PH_SZ   = $clog2(NPHASE);
  localparam logic [PH_SZ-1:0] LAST_PH = PH_SZ'(NPHASE - 1);

  logic [BIT_SZ-1:0] tbl_modulo [NPHASE];
  logic [REP_SZ-1:0] tbl_reps   [NPHASE];
  logic [1:0]        state;
  logic [PH_SZ-1:0]  phase;
  logic [BIT_SZ-1:0] work_modulo;
  logic [REP_SZ-1:0] reps_left;
  logic              busy;
  logic              wrap;
  logic              div_tick;
  logic              entry_skip;
  logic              last_ph;
`ifdef TICK_SEQ_LOOP_EN
  logic              ticked;
`endif

  assign busy       = is_busy(state);
  assign entry_skip = (tbl_modulo[phase] == '0) || (tbl_reps[phase] == '0);
  assign last_ph    = (phase == LAST_PH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPHASE; i++) begin
        tbl_modulo[i] <= '0;
        tbl_reps[i]   <= '0;
      end
    end else if (bus.cfg_we && !busy) begin
      tbl_modulo[bus.cfg_addr] <= bus.cfg_modulo;
      tbl_reps[bus.cfg_addr]   <= bus.cfg_reps;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      work_modulo <= '0;
      reps_left   <= '0;
`ifdef TICK_SEQ_LOOP_EN
      ticked      <= 1'b0;
`endif
    end else if (bus.abort) begin
      state <= S_IDLE;
      phase <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_LOAD;
          phase <= '0;
`ifdef TICK_SEQ_LOOP_EN
          ticked <= 1'b0;
`endif
        end
        S_LOAD: if (entry_skip) begin
          if (last_ph) state <= S_DONE;
          else         phase <= phase + PH_SZ'(1);
        end else begin
          // working copy isolates the running phase from table edits
          work_modulo <= tbl_modulo[phase];
          reps_left   <= tbl_reps[phase];
          state       <= S_RUN;
        end
        S_RUN: if (wrap && (reps_left != '0)) begin
          reps_left <= reps_left - REP_SZ'(1);
`ifdef TICK_SEQ_LOOP_EN
          ticked <= 1'b1;
`endif
          if (reps_left == REP_SZ'(1)) begin
            if (last_ph) state <= S_DONE;
            else begin
              state <= S_LOAD;
              phase <= phase + PH_SZ'(1);
            end
          end
        end
        S_DONE: begin
          phase <= '0;
`ifdef TICK_SEQ_LOOP_EN
          // a pass that emitted nothing would spin forever, so stop instead
          state  <= ticked ? S_LOAD : S_IDLE;
          ticked <= 1'b0;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tick_phase_sequencer_divider #(.BIT_SZ(BIT_SZ)) u_div (
    .clock  (clock),
    .reset  (reset),
    .run    (state == S_RUN),
    .enable (bus.enable),
    .clear  ((state != S_RUN) || bus.abort),
    .modulo (work_modulo),
    .tick   (div_tick),
    .wrap   (wrap)
  );

  assign bus.tick  = div_tick;
  assign bus.phase = phase;
  assign bus.busy  = busy;
  assign bus.done  = (state == S_DONE);
endmodule

// File: tb/tb_tick_phase_sequencer.sv
// Vector/scoreboard bench for tick_phase_sequencer (one-shot and TICK_SEQ_LOOP_EN builds).
module tb_tick_phase_sequencer;
  import tick_phase_sequencer_pkg::*;

  localparam int BIT_SZ = BIT_SZ_DEF;
  localparam int NPHASE = NPHASE_DEF;
  localparam int REP_SZ = REP_SZ_DEF;
`ifdef TICK_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct packed {
    logic       t;
    logic       b;
    logic       d;
    logic [1:0] ph;
  } exp_t;

  typedef struct {
    logic              en;
    logic              st;
    logic              ab;
    logic              we;
    logic [1:0]        addr;
    logic [BIT_SZ-1:0] mo;
    logic [REP_SZ-1:0] rp;
    exp_t              e;
  } vec_t;

  logic  clock = 1'b0;
  logic  reset;
  vec_t  vecs[$];
  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    base;
  string tname;

  always #5 clock = ~clock;

  tick_phase_sequencer_if #(.BIT_SZ(BIT_SZ), .NPHASE(NPHASE), .REP_SZ(REP_SZ)) bus ();

  tick_phase_sequencer #(.BIT_SZ(BIT_SZ), .NPHASE(NPHASE), .REP_SZ(REP_SZ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s tick.busy.done.phase actual=%b required=%b", name, act, req);
    end
  endtask

  function automatic void push(input logic en, input logic st, input logic ab, input exp_t e);
    vec_t v;
    v.en = en; v.st = st; v.ab = ab; v.we = 1'b0;
    v.addr = '0; v.mo = '0; v.rp = '0; v.e = e;
    vecs.push_back(v);
  endfunction

  function automatic void addw(input logic [1:0] a, input int mo, input int rp);
    vec_t v;
    v.en = 1'b0; v.st = 1'b0; v.ab = 1'b0; v.we = 1'b1;
    v.addr = a; v.mo = BIT_SZ'(mo); v.rp = REP_SZ'(rp); v.e = '0;
    vecs.push_back(v);
  endfunction

  // Table {3,2},{5,1},{0,4},{7,0}, enable held high, start at step 0
  function automatic void seq2(input int abort_at, input int len);
    exp_t tr [17];
    tr = '{'{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{1,1,0,0},
           '{0,1,0,0}, '{0,1,0,0}, '{1,1,0,1}, '{0,1,0,1}, '{0,1,0,1},
           '{0,1,0,1}, '{0,1,0,1}, '{0,1,0,1}, '{1,1,0,2}, '{0,1,0,3},
           '{0,0,1,3}, '{1'b0,LOOP,1'b0,2'd0}};
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        push(1'b1, 1'b0, 1'b1, '0);
        push(1'b1, 1'b0, 1'b0, '0);
        return;
      end
      push(1'b1, k == 0, 1'b0, tr[k]);
    end
    if (len == 17) push(1'b1, 1'b0, 1'b1, '0);
  endfunction

  // Entry0 {4,1}, rest zero; enable high on every third edge
  function automatic void seq3();
    exp_t tr [18];
    for (int k = 0; k < 13; k++) tr[k] = '{0,1,0,0};
    tr[13] = '{1,1,0,1};
    tr[14] = '{0,1,0,2};
    tr[15] = '{0,1,0,3};
    tr[16] = '{0,0,1,3};
    tr[17] = '{1'b0,LOOP,1'b0,2'd0};
    for (int k = 0; k < 18; k++) push((k % 3) == 1, k == 0, 1'b0, tr[k]);
    push(1'b1, 1'b0, 1'b1, '0);
  endfunction

  // Entry0 {2,1}, rest zero
  function automatic void seq6();
    exp_t tr [7];
    tr = '{'{0,1,0,0}, '{0,1,0,0}, '{0,1,0,0}, '{1,1,0,1},
           '{0,1,0,2}, '{0,1,0,3}, '{0,0,1,3}};
    for (int k = 0; k < 7; k++) push(1'b1, k == 0, 1'b0, tr[k]);
`ifdef TICK_SEQ_LOOP_EN
    for (int k = 0; k < 7; k++) push(1'b1, 1'b0, 1'b0, tr[k]);
    push(1'b1, 1'b0, 1'b0, '{0,1,0,0});
    push(1'b1, 1'b0, 1'b1, '0);
`else
    push(1'b1, 1'b0, 1'b0, '0);
`endif
  endfunction

  function automatic void seq_zero();
    push(1'b1, 1'b1, 1'b0, '{0,1,0,0});
    push(1'b1, 1'b0, 1'b0, '{0,1,0,1});
    push(1'b1, 1'b0, 1'b0, '{0,1,0,2});
    push(1'b1, 1'b0, 1'b0, '{0,1,0,3});
    push(1'b1, 1'b0, 1'b0, '{0,0,1,3});
    push(1'b1, 1'b0, 1'b0, '0);
    push(1'b1, 1'b0, 1'b0, '0);
  endfunction

  task automatic run_vecs();
    exp_t got;
    foreach (vecs[i]) begin
      bus.enable     = vecs[i].en;
      bus.start      = vecs[i].st;
      bus.abort      = vecs[i].ab;
      bus.cfg_we     = vecs[i].we;
      bus.cfg_addr   = vecs[i].addr;
      bus.cfg_modulo = vecs[i].mo;
      bus.cfg_reps   = vecs[i].rp;
      sb.push_back(vecs[i].e);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      check($sformatf("%s[%0d]", tname, i), {bus.tick, bus.busy, bus.done, bus.phase}, got);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0; bus.cfg_modulo = '0; bus.cfg_reps = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {bus.tick, bus.busy, bus.done, bus.phase}, 5'b0);
    reset = 1'b0;

    tname = "seq_basic";
    addw(0, 3, 2); addw(1, 5, 1); addw(2, 0, 4); addw(3, 7, 0);
    seq2(-1, 17);
    run_vecs();

    tname = "abort";
    seq2(13, 17);
    seq2(-1, 17);
    run_vecs();

    tname = "busy_edit";
    base = vecs.size();
    seq2(-1, 17);
    vecs[base+2].we = 1'b1;
    vecs[base+2].st = 1'b1;
    vecs[base+2].mo = BIT_SZ'(1);
    vecs[base+2].rp = REP_SZ'(1);
    seq2(-1, 17);
    run_vecs();

    tname = "reset_pre";
    seq2(-1, 5);
    run_vecs();
    #2 reset = 1'b1;
    #1 check("reset_async", {bus.tick, bus.busy, bus.done, bus.phase}, 5'b0);
    @(posedge clock);
    #1 check("reset_hold", {bus.tick, bus.busy, bus.done, bus.phase}, 5'b0);
    reset = 1'b0;
    tname = "table_cleared";
    seq_zero();
    run_vecs();

    tname = "sparse_enable";
    addw(0, 4, 1);
    seq3();
    run_vecs();

    tname = "short_table";
    addw(0, 2, 1);
    seq6();
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
